// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit seven-segment driver for a scanned common-anode display.
// A free-running converter samples `number`/`mode` and produces either hex
// nibbles or BCD digits (sequential double-dabble). The result is copied
// atomically into the shown register. A refresh counter steps through the digits.
//
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   number    - value to display, sampled when a conversion starts
//   mode      - 0 = hex, 1 = unsigned decimal, sampled when a conversion starts
//   blank_lz  - blank leading zeros (digit 0 is never blanked)
//   empty     - force every anode inactive; scanning keeps running
//   dp        - decimal point per digit (bit i = digit i)
//   seg       - segments a..g on seg[0]..seg[6]
//   dp_out    - decimal point of the active digit
//   an        - anode enables, an[0] = rightmost digit
//   overflow  - decimal value needs more than DIGITS digits
//   busy      - conversion in progress
module seg7_scan_display #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  number,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic              empty,
  input  logic [DIGITS-1:0] dp,
  output logic [6:0]        seg,
  output logic              dp_out,
  output logic [DIGITS-1:0] an,
  output logic              overflow,
  output logic              busy
);

  localparam int          SHOW_W = 4 * DIGITS;
  localparam int          BCD_W  = 4 * DIGITS + 4;
  localparam int unsigned NIBS   = DIGITS + 1;
  localparam int          CNT_W  = $clog2(REFRESH_DIV);
  localparam int          IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          IT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_sr;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic                mode_l;
  logic                lost;
  logic [IT_W-1:0]     it_cnt;
  logic [SHOW_W-1:0]   shown;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic [3:0]          cur_digit;
  logic [SHOW_W-1:0]   upper;
  logic                lead_blank;
  logic [6:0]          seg_act;
  logic [DIGITS-1:0]   an_act;
  logic                dp_act;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A 1 shifted out of the guard nibble is remembered in `lost`, so overflow
  // stays correct even where the value needs two digits beyond DIGITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bin_sr   <= '0;
      bcd      <= '0;
      mode_l   <= 1'b0;
      lost     <= 1'b0;
      it_cnt   <= '0;
      shown    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bin_sr <= number;
          mode_l <= mode;
          bcd    <= '0;
          lost   <= 1'b0;
          it_cnt <= '0;
          busy   <= 1'b1;
          state  <= S_CONV;
        end
        S_CONV: begin
          if (!mode_l) begin
            bcd   <= BCD_W'(bin_sr);
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
            bin_sr <= bin_sr << 1;
            lost   <= lost | bcd_adj[BCD_W-1];
            it_cnt <= it_cnt + 1'b1;
            if (it_cnt == IT_W'(WIDTH - 1)) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          shown    <= bcd[SHOW_W-1:0];
          overflow <= mode_l & ((bcd[BCD_W-1 -: 4] != 4'd0) | lost);
          busy     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    cur_digit  = shown[{idx, 2'b00} +: 4];
    upper      = shown >> {idx, 2'b00};
    lead_blank = blank_lz && (idx != '0) && (upper == '0);
    if (overflow)        seg_act = 7'b1000000;
    else if (lead_blank) seg_act = 7'b0000000;
    else                 seg_act = glyph(cur_digit);
    an_act      = '0;
    an_act[idx] = 1'b1;
    dp_act      = dp[idx];
    if (empty) begin
      an_act  = '0;
      seg_act = '0;
      dp_act  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= {DIGITS{ACTIVE_LOW}};
      seg    <= {7{ACTIVE_LOW}};
      dp_out <= ACTIVE_LOW;
    end else begin
      an     <= an_act ^ {DIGITS{ACTIVE_LOW}};
      seg    <= seg_act ^ {7{ACTIVE_LOW}};
      dp_out <= dp_act ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (DIGITS=4, WIDTH=16, REFRESH_DIV=4,
// active-low). Expected glyphs come from arithmetic on the applied number;
// the expected active digit comes from the count of cycles since reset.
module tb_seg7_scan_display;

  localparam int D = 4;
  localparam int W = 16;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  number;
  logic          mode, blank_lz, empty;
  logic [D-1:0]  dp;
  logic [6:0]    seg;
  logic          dp_out;
  logic [D-1:0]  an;
  logic          overflow, busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned k;

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  seg7_scan_display #(
    .DIGITS(D), .WIDTH(W), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .number(number), .mode(mode), .blank_lz(blank_lz),
    .empty(empty), .dp(dp), .seg(seg), .dp_out(dp_out), .an(an),
    .overflow(overflow), .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned p10(input int unsigned d);
    int unsigned r = 1;
    for (int unsigned i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit exp_ovf(input int unsigned n, input bit md);
    return md && (n >= p10(D));
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned n, input bit md,
                                         input bit blz, input int unsigned d);
    int unsigned q;
    if (exp_ovf(n, md)) return 7'b0111111;
    q = md ? n / p10(d) : n >> (4 * d);
    if (blz && d != 0 && q == 0) return 7'h7F;
    return ~glyph_tbl[md ? q % 10 : q % 16];
  endfunction

  // Checks the registered outputs at a negedge, given the value that should be shown.
  task automatic step(input string tag, input int unsigned n, input bit md);
    int unsigned ix;
    logic [D-1:0] ea;
    logic [6:0]   es;
    logic         edp;
    ix = ((k - 1) / R) % D;
    if (empty) begin
      ea = '1; es = '1; edp = 1'b1;
    end else begin
      ea  = ~(D'(1) << ix);
      es  = exp_seg(n, md, blank_lz, ix);
      edp = ~dp[ix];
    end
    chk({tag, ".an"}, 32'(an), 32'(ea));
    chk({tag, ".seg"}, 32'(seg), 32'(es));
    chk({tag, ".dp"}, 32'(dp_out), 32'(edp));
  endtask

  task automatic show(input string tag, input int unsigned n, input bit md, input int unsigned cyc);
    repeat (cyc) begin
      @(negedge clk);
      step(tag, n, md);
    end
    chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf(n, md)));
  endtask

  task automatic apply(input string tag, input int unsigned n, input bit md,
                       input bit blz, input logic [D-1:0] dpv);
    @(negedge clk);
    number = W'(n); mode = md; blank_lz = blz; dp = dpv;
    repeat (40) @(negedge clk);
    show(tag, n, md, 2 * D * R);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".an"}, 32'(an), 32'hF);
    chk({tag, ".seg"}, 32'(seg), 32'h7F);
    chk({tag, ".dp"}, 32'(dp_out), 32'h1);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".ovf"}, 32'(overflow), 32'h0);
  endtask

  task automatic sync_done(input string tag);
    int unsigned t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy !== 1'b0 && t < 100);
    chk({tag, ".sync"}, 32'(t < 100), 32'h1);
  endtask

  initial begin
    int unsigned v, hi, n;
    bit md, blz;

    rst = 1'b1; number = W'(12345); mode = 1'b1; blank_lz = 1'b0; empty = 1'b0; dp = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Scan order from reset, shown value 0, decimal latency of WIDTH+2.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      step("boot", 0, 1'b0);
      if (i == 1) chk("boot.busy_hi", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("lat.ovf_before", 32'(overflow), 32'h0);
    chk("lat.busy_lo", 32'(busy), 32'h0);
    @(negedge clk);
    chk("lat.ovf_after", 32'(overflow), 32'h1);

    apply("dec1234", 1234, 1'b1, 1'b0, 4'b0000);
    apply("dec12345", 12345, 1'b1, 1'b0, 4'b0101);
    apply("hex3039", 12345, 1'b0, 1'b0, 4'b0000);
    apply("hexA5_blz", 16'h00A5, 1'b0, 1'b1, 4'b1000);
    apply("hex0_blz", 0, 1'b0, 1'b1, 4'b0000);
    apply("dec0_blz", 0, 1'b1, 1'b1, 4'b0010);
    apply("dec9999", 9999, 1'b1, 1'b1, 4'b0000);
    apply("dec10000", 10000, 1'b1, 1'b0, 4'b1111);
    apply("hexFFFF", 16'hFFFF, 1'b0, 1'b0, 4'b0000);
    apply("dec0105_blz", 105, 1'b1, 1'b1, 4'b0000);

    // Number changes every cycle during a decimal conversion.
    apply("pre_hold", 4321, 1'b1, 1'b0, 4'b0000);
    v = $urandom_range(0, 9999);
    if (v == 4321) v = 1234;
    sync_done("hold");
    number = W'(v);
    hi = 0;
    @(negedge clk);
    if (busy === 1'b1) hi++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
      number = W'($urandom);
    end
    @(negedge clk);
    chk("hold.busy_run", 32'(hi), 32'd17);
    chk("hold.busy_lo", 32'(busy), 32'h0);
    number = W'(v);
    @(negedge clk);
    show("hold", v, 1'b1, 16);

    // Reset in the middle of a decimal conversion and mid-scan.
    sync_done("rstmid");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rstmid");
    rst = 1'b0;
    show("post_rst", 0, 1'b0, 16);

    // Empty blanks every anode; scan position keeps advancing underneath.
    apply("pre_empty", 16'h1A2B, 1'b0, 1'b0, 4'b0110);
    @(negedge clk);
    empty = 1'b1;
    show("empty", 16'h1A2B, 1'b0, 10);
    empty = 1'b0;
    show("resume", 16'h1A2B, 1'b0, 16);

    for (int i = 0; i < 8; i++) begin
      n   = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      md  = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      apply("rand", n, md, blz, D'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
